param_dpram: RTL and testbench

- Parametrised single-clock true dual-port RAM. Successor to the fixed 4096x32 dual-port memory.
- Adds configurable width and depth, per-byte write enables, and a selectable read-during-write mode.
- Adds an optional output pipeline register, a built-in memory-clear engine, and write-collision detection.
- Used as shared instruction/data memory between CPU core and bus masters.

---
 rtl/param_dpram.sv | 205 ++++++++++++++++++++
 tb/tb_param_dpram.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/param_dpram.sv
// param_dpram: parameterised single-clock true dual-port RAM with byte
// enables, selectable read-during-write behaviour, optional output register,
// a memory-clear engine and write-collision detection.
//
// Storage is split into one 8-bit lane per byte. Each lane is a plain
// two-write/two-read RAM with unreset contents. Read-during-write forwarding
// is done with a small registered bypass beside the read register, so the
// array itself only does read-first accesses.

// One byte lane: storage, registered read and same-address forwarding.
module param_dpram_lane #(
  parameter int ADDR_W   = 12,
  parameter int RDW_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_a,
  input  logic              rd_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [7:0]        din_a,
  input  logic              we_b,
  input  logic              rd_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [7:0]        din_b,
  input  logic              same_addr,
  output logic [7:0]        q_a,
  output logic [7:0]        q_b
);
  logic [7:0] mem [2**ADDR_W];
  logic [7:0] rdat_a, rdat_b, byp_d_a, byp_d_b;
  logic       byp_a, byp_b;
  logic       hit_a, hit_b;

  // A read sees a write to its own address from either port; B wins overlaps.
  assign hit_a = we_a | (we_b & same_addr);
  assign hit_b = we_b | (we_a & same_addr);

  // Array writes; on an overlapping collision only port B lands.
  always_ff @(posedge clk) begin
    if (we_a && !(we_b && same_addr)) mem[addr_a] <= din_a;
    if (we_b) mem[addr_b] <= din_b;
  end

  // Port A read register plus write-first bypass; holds while not enabled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdat_a  <= '0;
      byp_a   <= 1'b0;
      byp_d_a <= '0;
    end else if (rd_a) begin
      rdat_a  <= mem[addr_a];
      byp_a   <= (RDW_MODE == 0) && hit_a;
      byp_d_a <= (we_b && same_addr) ? din_b : din_a;
    end
  end

  // Port B read register plus write-first bypass; holds while not enabled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdat_b  <= '0;
      byp_b   <= 1'b0;
      byp_d_b <= '0;
    end else if (rd_b) begin
      rdat_b  <= mem[addr_b];
      byp_b   <= (RDW_MODE == 0) && hit_b;
      byp_d_b <= we_b ? din_b : din_a;
    end
  end

  assign q_a = byp_a ? byp_d_a : rdat_a;
  assign q_b = byp_b ? byp_d_b : rdat_b;
endmodule

// Top level: clear FSM, port muxing, collision flag and output stage.
module param_dpram #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 12,
  parameter int                RDW_MODE  = 0,
  parameter int                OUT_REG   = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_req,
  output logic                busy,
  output logic                coll,
  input  logic                ena,
  input  logic [DATA_W/8-1:0] wea,
  input  logic [ADDR_W-1:0]   addra,
  input  logic [DATA_W-1:0]   dina,
  output logic [DATA_W-1:0]   douta,
  input  logic                enb,
  input  logic [DATA_W/8-1:0] web,
  input  logic [ADDR_W-1:0]   addrb,
  input  logic [DATA_W-1:0]   dinb,
  output logic [DATA_W-1:0]   doutb
);
  localparam int NUM_LANES = DATA_W / 8;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                          state, state_nx;
  logic [ADDR_W-1:0]               cnt, cnt_nx;
  logic                            ready, clr_go;
  logic                            rd_a, rd_b, same_addr;
  logic [ADDR_W-1:0]               addr_a_m;
  logic [NUM_LANES-1:0]            we_a_l, we_b_l;
  logic [NUM_LANES-1:0][7:0]       din_a_m, din_b_l, q_a, q_b;

  // Reset gates everything so the array is never written while it is held.
  assign ready  = (state == READY) && reset;
  assign clr_go = (state == CLEAR) && reset;
  assign busy   = (state == CLEAR);

  // FSM state and clear address register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state: sweep every address once, then serve the ports.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      CLEAR: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == '1) state_nx = READY;
      end
      READY: begin
        if (clear_req) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end
      end
      default: state_nx = CLEAR;
    endcase
  end

  // The clear engine borrows port A's write path.
  assign addr_a_m  = clr_go ? cnt : addra;
  assign rd_a      = ready && ena;
  assign rd_b      = ready && enb;
  assign same_addr = (addr_a_m == addrb);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign we_a_l[i]  = clr_go | (ready & ena & wea[i]);
    assign we_b_l[i]  = ready & enb & web[i];
    assign din_a_m[i] = clr_go ? CLEAR_VAL[i*8 +: 8] : dina[i*8 +: 8];
    assign din_b_l[i] = dinb[i*8 +: 8];

    param_dpram_lane #(.ADDR_W(ADDR_W), .RDW_MODE(RDW_MODE)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .we_a      (we_a_l[i]),
      .rd_a      (rd_a),
      .addr_a    (addr_a_m),
      .din_a     (din_a_m[i]),
      .we_b      (we_b_l[i]),
      .rd_b      (rd_b),
      .addr_b    (addrb),
      .din_b     (din_b_l[i]),
      .same_addr (same_addr),
      .q_a       (q_a[i]),
      .q_b       (q_b[i])
    );
  end

  // Collision pulse rises on the write edge itself, independent of OUT_REG.
  always_ff @(posedge clk) begin
    if (!reset) coll <= 1'b0;
    else        coll <= ready && ena && enb && (addra == addrb) && |(wea & web);
  end

  if (OUT_REG != 0) begin : g_oreg
    logic              vld_a, vld_b;
    logic [DATA_W-1:0] dout_ra, dout_rb;

    // Output stage only advances behind an enabled access, so it holds too.
    always_ff @(posedge clk) begin
      if (!reset) begin
        vld_a   <= 1'b0;
        vld_b   <= 1'b0;
        dout_ra <= '0;
        dout_rb <= '0;
      end else begin
        vld_a <= rd_a;
        vld_b <= rd_b;
        if (vld_a) dout_ra <= q_a;
        if (vld_b) dout_rb <= q_b;
      end
    end

    assign douta = dout_ra;
    assign doutb = dout_rb;
  end else begin : g_nooreg
    assign douta = q_a;
    assign doutb = q_b;
  end
endmodule

// File: tb/tb_param_dpram.sv
// Directed bench for param_dpram. Two instances share all inputs:
// dut0 is write-first without output register, dut1 is read-first with it.
module tb_param_dpram;
  localparam logic [31:0] CV = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        reset, clear_req;
  logic        ena, enb;
  logic [3:0]  wea, web, addra, addrb;
  logic [31:0] dina, dinb;
  logic        busy0, coll0, busy1, coll1;
  logic [31:0] douta0, doutb0, douta1, doutb1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  param_dpram #(.DATA_W(32), .ADDR_W(4), .RDW_MODE(0), .OUT_REG(0), .CLEAR_VAL(CV)) dut0 (
    .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy0), .coll(coll0),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta0),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb0));

  param_dpram #(.DATA_W(32), .ADDR_W(4), .RDW_MODE(1), .OUT_REG(1), .CLEAR_VAL(CV)) dut1 (
    .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy1), .coll(coll1),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta1),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0; clear_req = 1'b0;
  endtask

  task automatic wr_a(input logic [3:0] a, input logic [31:0] d, input logic [3:0] we);
    ena = 1'b1; wea = we; addra = a; dina = d;
    step();
    ena = 1'b0; wea = '0;
  endtask

  task automatic rd_a(input logic [3:0] a);
    ena = 1'b1; wea = '0; addra = a;
    step();
    ena = 1'b0;
    step();
  endtask

  task automatic rd_b(input logic [3:0] a);
    enb = 1'b1; web = '0; addrb = a;
    step();
    enb = 1'b0;
    step();
  endtask

  task automatic test_reset();
    int cyc;
    reset = 1'b0; idle(); addra = '0; addrb = '0; dina = '0; dinb = '0;
    repeat (3) step();
    n_tests++; if (busy0 !== 1'b1 || busy1 !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b/%b expected 1", busy0, busy1); end
    n_tests++; if (douta0 !== 32'h0 || doutb0 !== 32'h0 || douta1 !== 32'h0 || doutb1 !== 32'h0) begin
      n_fail++; $display("FAIL reset_dout: got %h %h %h %h expected 0", douta0, doutb0, douta1, doutb1); end
    n_tests++; if (coll0 !== 1'b0) begin n_fail++; $display("FAIL reset_coll: got %b expected 0", coll0); end
    reset = 1'b1;
    cyc = 0;
    while (busy0 === 1'b1 && cyc < 100) begin step(); cyc++; end
    n_tests++; if (cyc != 16) begin n_fail++; $display("FAIL reset_clear_len: got %0d cycles expected 16", cyc); end
    n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy1_drop: got %b expected 0", busy1); end
  endtask

  task automatic test_clear_values();
    for (int a = 0; a < 16; a++) begin
      rd_a(4'(a));
      n_tests++; if (douta0 !== CV || douta1 !== CV) begin
        n_fail++; $display("FAIL clear_val[%0d]: got %h/%h expected %h", a, douta0, douta1, CV); end
    end
  endtask

  task automatic test_byte_write();
    wr_a(4'd3, 32'h1122_3344, 4'hF);
    wr_a(4'd3, 32'hAABB_CCDD, 4'b0101);
    n_tests++; if (douta0 !== 32'h11BB_33DD) begin n_fail++; $display("FAIL byte_wr_first: got %h expected 11bb33dd", douta0); end
    ena = 1'b1; addra = 4'd3;
    step();
    ena = 1'b0;
    n_tests++; if (douta0 !== 32'h11BB_33DD) begin n_fail++; $display("FAIL byte_rd_lat1: got %h expected 11bb33dd", douta0); end
    n_tests++; if (douta1 !== 32'h1122_3344) begin n_fail++; $display("FAIL byte_rd_lat2_early: got %h expected 11223344", douta1); end
    step();
    n_tests++; if (douta1 !== 32'h11BB_33DD) begin n_fail++; $display("FAIL byte_rd_lat2: got %h expected 11bb33dd", douta1); end
  endtask

  task automatic test_rdw_cross();
    wr_a(4'd5, 32'h0, 4'hF);
    ena = 1'b1; wea = 4'hF; addra = 4'd5; dina = 32'hFFFF_FFFF;
    enb = 1'b1; web = 4'h0; addrb = 4'd5;
    step();
    ena = 1'b0; enb = 1'b0; wea = '0;
    n_tests++; if (doutb0 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rdw_wf: got %h expected ffffffff", doutb0); end
    step();
    n_tests++; if (doutb1 !== 32'h0) begin n_fail++; $display("FAIL rdw_rf: got %h expected 00000000", doutb1); end
    rd_b(4'd5);
    n_tests++; if (doutb0 !== 32'hFFFF_FFFF || doutb1 !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL rdw_after: got %h/%h expected ffffffff", doutb0, doutb1); end
  endtask

  task automatic test_collision();
    wr_a(4'd7, 32'h9988_7766, 4'hF);
    ena = 1'b1; wea = 4'b0011; addra = 4'd7; dina = 32'h0000_1111;
    enb = 1'b1; web = 4'b0110; addrb = 4'd7; dinb = 32'h0022_2200;
    step();
    n_tests++; if (coll0 !== 1'b1 || coll1 !== 1'b1) begin n_fail++; $display("FAIL coll_pulse: got %b/%b expected 1", coll0, coll1); end
    n_tests++; if (douta0 !== 32'h9922_2211 || doutb0 !== 32'h9922_2211) begin
      n_fail++; $display("FAIL coll_wf: got %h/%h expected 99222211", douta0, doutb0); end
    wea = '0; web = '0;
    step();
    ena = 1'b0; enb = 1'b0;
    n_tests++; if (coll0 !== 1'b0 || coll1 !== 1'b0) begin n_fail++; $display("FAIL coll_rr: got %b/%b expected 0", coll0, coll1); end
    rd_a(4'd7);
    n_tests++; if (douta0 !== 32'h9922_2211 || douta1 !== 32'h9922_2211) begin
      n_fail++; $display("FAIL coll_mem: got %h/%h expected 99222211", douta0, douta1); end
  endtask

  task automatic test_enable_hold();
    wr_a(4'd9, 32'hCAFE_F00D, 4'hF);
    rd_a(4'd9);
    for (int i = 0; i < 4; i++) begin
      ena = 1'b0; wea = 4'hF; addra = 4'd9; dina = 32'h1234_5678;
      step();
      n_tests++; if (douta0 !== 32'hCAFE_F00D || douta1 !== 32'hCAFE_F00D) begin
        n_fail++; $display("FAIL en_hold[%0d]: got %h/%h expected cafef00d", i, douta0, douta1); end
    end
    wea = '0;
    rd_a(4'd9);
    n_tests++; if (douta0 !== 32'hCAFE_F00D || douta1 !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL en_nowrite: got %h/%h expected cafef00d", douta0, douta1); end
  endtask

  task automatic test_clear_req();
    int cyc;
    clear_req = 1'b1; ena = 1'b1; wea = 4'hF; addra = 4'd2; dina = 32'h5555_5555;
    step();
    clear_req = 1'b0; ena = 1'b0; wea = '0;
    n_tests++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL clrreq_busy: got %b expected 1", busy0); end
    n_tests++; if (douta0 !== 32'h5555_5555) begin n_fail++; $display("FAIL clrreq_access: got %h expected 55555555", douta0); end
    cyc = 0;
    while (busy0 === 1'b1 && cyc < 100) begin step(); cyc++; end
    n_tests++; if (cyc != 16) begin n_fail++; $display("FAIL clrreq_len: got %0d cycles expected 16", cyc); end
    rd_a(4'd3);
    n_tests++; if (douta0 !== CV || douta1 !== CV) begin n_fail++; $display("FAIL clrreq_mem3: got %h/%h expected %h", douta0, douta1, CV); end
    rd_a(4'd2);
    n_tests++; if (douta0 !== CV) begin n_fail++; $display("FAIL clrreq_mem2: got %h expected %h", douta0, CV); end
  endtask

  task automatic test_reset_mid_clear();
    int cyc;
    wr_a(4'd12, 32'h1212_1212, 4'hF);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (9) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    n_tests++; if (busy0 !== 1'b1 || douta0 !== 32'h0 || douta1 !== 32'h0) begin
      n_fail++; $display("FAIL midrst_state: got busy=%b dout=%h/%h expected 1/0/0", busy0, douta0, douta1); end
    cyc = 0;
    while (busy0 === 1'b1 && cyc < 100) begin step(); cyc++; end
    n_tests++; if (cyc != 16) begin n_fail++; $display("FAIL midrst_len: got %0d cycles expected 16", cyc); end
    rd_a(4'd12);
    n_tests++; if (douta0 !== CV || douta1 !== CV) begin n_fail++; $display("FAIL midrst_mem: got %h/%h expected %h", douta0, douta1, CV); end
  endtask

  initial begin
    test_reset();
    test_clear_values();
    test_byte_write();
    test_rdw_cross();
    test_collision();
    test_enable_hold();
    test_clear_req();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
